// File: rtl/sdram_read_arb.sv
// Round-robin read arbiter: grants one cache miss-handler burst at a time,
// splits it into single-word SDRAM reads and routes returned words back to the owner.
`timescale 1ns/1ps
module sdram_read_arb #(
  parameter  int NUM_CACHES = 3,
  parameter  int MAX_TRANS  = 16,
  localparam int TS_W       = $clog2(MAX_TRANS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CACHES-1:0][24:0]         addr_cache_to_sdram,
  input  logic [NUM_CACHES-1:0][TS_W-1:0]     transSize,
  input  logic [NUM_CACHES-1:0]               readReq,
  output logic [NUM_CACHES-1:0]               readValid_out,
  output logic [NUM_CACHES-1:0][31:0]         readData,
  output logic [NUM_CACHES-1:0]               doneRead,
  output logic                                mem_rd_req,
  output logic [24:0]                         mem_rd_addr,
  input  logic                                mem_rd_ready,
  input  logic                                mem_rd_valid,
  input  logic [31:0]                         mem_rd_data,
  output logic                                stray_err
);

  localparam int ID_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   ptr_q, id_q;
  logic [24:0]       start_q;
  logic [TS_W:0]     words_q, issued_q, received_q;
  logic              rvalid_q, done_q;
  logic [31:0]       rdata_q;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_id, ptr_next, idx;
  int                cand;
  logic              req_fire, rsp_ok, last_rsp;

  // Round-robin pick: first requester at or after ptr_q, wrapping.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    cand      = 0;
    for (int k = 0; k < NUM_CACHES; k++) begin
      if (!gnt_found) begin
        cand = int'(ptr_q) + k;
        if (cand >= NUM_CACHES) cand = cand - NUM_CACHES;
        idx = ID_W'(cand);
        if (readReq[idx]) begin
          gnt_found = 1'b1;
          gnt_id    = idx;
        end
      end
    end
    cand     = int'(gnt_id) + 1;
    ptr_next = (cand >= NUM_CACHES) ? '0 : ID_W'(cand);
  end

  assign mem_rd_req  = (state == ISSUE) && (issued_q < words_q);
  assign mem_rd_addr = start_q + 25'(issued_q);
  assign req_fire    = mem_rd_req && mem_rd_ready;
  assign rsp_ok      = mem_rd_valid && (state == ISSUE) && (received_q < words_q);
  assign last_rsp    = rsp_ok && ((received_q + 1'b1) == words_q);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (gnt_found) state_next = ISSUE;
      ISSUE:   if (last_rsp)  state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      id_q       <= '0;
      start_q    <= '0;
      words_q    <= '0;
      issued_q   <= '0;
      received_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      stray_err  <= 1'b0;
    end else begin
      if (state == IDLE && gnt_found) begin
        id_q       <= gnt_id;
        start_q    <= addr_cache_to_sdram[gnt_id];
        words_q    <= (TS_W+1)'(transSize[gnt_id]) + (TS_W+1)'(1);
        issued_q   <= '0;
        received_q <= '0;
        ptr_q      <= ptr_next;
      end else begin
        // Issue and return paths advance independently within a burst.
        if (req_fire) issued_q   <= issued_q + 1'b1;
        if (rsp_ok)   received_q <= received_q + 1'b1;
      end
      rvalid_q <= rsp_ok;
      rdata_q  <= rsp_ok ? mem_rd_data : '0;
      done_q   <= last_rsp;
      if (mem_rd_valid && !rsp_ok) stray_err <= 1'b1;
    end
  end

  // Only the granted lane ever sees a strobe, data or done pulse.
  always_comb begin
    readValid_out       = '0;
    doneRead            = '0;
    readData            = '0;
    readValid_out[id_q] = rvalid_q;
    doneRead[id_q]      = done_q;
    readData[id_q]      = rdata_q;
  end

endmodule

// File: doc/sdram_read_arb.md
SDRAM_READ_ARB -- requirements
Module: sdram_read_arb

Interface
REQ-001 Parameter NUM_CACHES, default 3, number of cache miss-handler requesters (index 0 icache, 1 t0cache, 2 lcache).
REQ-002 Parameter MAX_TRANS, default 16, maximum burst length in words; TS_W = $clog2(MAX_TRANS).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port addr_cache_to_sdram  input  [NUM_CACHES-1:0][24:0]  per-cache burst start word address.
REQ-006 Port transSize  input  [NUM_CACHES-1:0][TS_W-1:0]  per-cache burst length minus one (words = transSize+1).
REQ-007 Port readReq  input  [NUM_CACHES-1:0]  per-cache level request; held with addr/transSize stable until doneRead sampled high, dropped on that same edge.
REQ-008 Port readValid_out  output  [NUM_CACHES-1:0]  per-cache one-word data strobe.
REQ-009 Port readData  output  [NUM_CACHES-1:0][31:0]  per-cache returned word.
REQ-010 Port doneRead  output  [NUM_CACHES-1:0]  per-cache one-cycle burst-complete pulse.
REQ-011 Port mem_rd_req  output  1  single-word read request to SDRAM controller.
REQ-012 Port mem_rd_addr  output  25  word address of mem_rd_req.
REQ-013 Port mem_rd_ready  input  1  controller accepts request when mem_rd_req and mem_rd_ready both high.
REQ-014 Port mem_rd_valid  input  1  in-order returned word strobe, arbitrary latency.
REQ-015 Port mem_rd_data  input  32  returned word.
REQ-016 Port stray_err  output  1  sticky flag: mem_rd_valid seen with no outstanding word.

Function
REQ-017 FSM states IDLE, ISSUE, DONE; the block SHALL serve exactly one burst at a time.
REQ-018 IDLE: if any readReq high, grant round-robin starting at pointer ptr; latch grant id, start address, words=transSize+1; go ISSUE; ptr <= (id+1) mod NUM_CACHES.
REQ-019 IDLE with no readReq: remain IDLE, mem_rd_req low.
REQ-020 ISSUE: mem_rd_req high, mem_rd_addr = start + issued (mod 2^25) while issued < words; issued increments on each accepted request; mem_rd_req low once issued == words.
REQ-021 Each mem_rd_valid while received < words SHALL, one cycle later, drive readValid_out[id]=1 and readData[id]=mem_rd_data; received increments.
REQ-022 Responses may arrive while requests still issuing; both counters update in the same cycle independently.
REQ-023 When the final word is received, next cycle is DONE: doneRead[id]=1 for exactly one cycle (coincident with last readValid_out[id]), then IDLE.
REQ-024 Non-granted cache lanes: readValid_out=0, doneRead=0, readData=0 at all times.
REQ-025 mem_rd_valid in IDLE or DONE, or beyond words, SHALL be dropped and set stray_err; stray_err clears only on reset.
REQ-026 transSize = MAX_TRANS-1 yields MAX_TRANS words; counters TS_W+1 bits wide; no overflow.
REQ-027 Minimum burst turnaround: grant-to-next-grant no shorter than words + memory latency + 2 cycles; no request issued in DONE.

Reset
REQ-028 On rst low, asynchronously: state IDLE, ptr 0, counters 0, mem_rd_req 0, mem_rd_addr 0, readValid_out 0, readData 0, doneRead 0, stray_err 0.
REQ-029 Reset mid-burst abandons the burst; responses arriving after reset release are dropped and flag stray_err.

Verification
REQ-030 Single request: readReq[1]=1, addr 0x1000, transSize 3, 2-cycle memory latency -> addrs 0x1000..0x1003 issued, four readValid_out[1] strobes with matching data, doneRead[1] pulse on fourth.
REQ-031 All three readReq high simultaneously from reset -> grants in order 0,1,2; second round after re-request starts at 0 again.
REQ-032 mem_rd_ready toggled 1-0-1-0 -> addresses advance only on accepted cycles; no address skipped or repeated.
REQ-033 addr 0x1FFFFFE, transSize 3 -> mem_rd_addr sequence 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001.
REQ-034 Assert rst after 2 of 8 words returned, release, inject one mem_rd_valid -> outputs zero during reset, no readValid_out, stray_err=1.
REQ-035 transSize 15 (MAX_TRANS 16) -> exactly 16 strobes, doneRead once, stray_err stays 0.
